// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, taken-branch flushes,
// data-memory freezes and EXE forwarding selects. Define HAZARD_PERF_EN to add stall/flush counters.
module hazard_ctrl (
  input  logic       CLK,
  input  logic       reset,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic [4:0] EXE_Rw,
  input  logic       EXE_RegWr,
  input  logic       EXE_MemtoReg,
  input  logic [4:0] MEM_Rw,
  input  logic       MEM_RegWr,
  input  logic       Branch_Taken,
  input  logic       MEM_Busy,
  output logic       PC_Write,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       IDEXE_Bubble,
  output logic       Freeze,
  output logic [1:0] EXE_ForwardA,
  output logic [1:0] EXE_ForwardB,
  output logic [1:0] Hazard_State
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] Stall_Cnt,
  output logic [15:0] Flush_Cnt
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    FLUSH   = 2'b10,
    WAIT    = 2'b11
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       exe_match_a;
  logic       exe_match_b;
  logic       mem_match_a;
  logic       mem_match_b;
  logic       load_use;
  logic [1:0] fwd_a_id;
  logic [1:0] fwd_b_id;

  // Register 0 is hardwired to zero, so a write to it never creates a dependency.
  assign exe_match_a = EXE_RegWr && (EXE_Rw != 5'd0) && (ID_Rs == EXE_Rw);
  assign exe_match_b = ID_UsesRt && EXE_RegWr && (EXE_Rw != 5'd0) && (ID_Rt == EXE_Rw);
  assign mem_match_a = MEM_RegWr && (MEM_Rw != 5'd0) && (ID_Rs == MEM_Rw);
  assign mem_match_b = ID_UsesRt && MEM_RegWr && (MEM_Rw != 5'd0) && (ID_Rt == MEM_Rw);
  assign load_use    = EXE_MemtoReg && (exe_match_a || exe_match_b);

  assign fwd_a_id = exe_match_a ? 2'b10 : (mem_match_a ? 2'b01 : 2'b00);
  assign fwd_b_id = exe_match_b ? 2'b10 : (mem_match_b ? 2'b01 : 2'b00);

  always_comb begin
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEXE_Bubble = 1'b0;
    Freeze       = 1'b0;
    state_next   = RUN;
    if (MEM_Busy) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      Freeze     = 1'b1;
      state_next = WAIT;
    end else if (Branch_Taken) begin
      IFID_Flush   = 1'b1;
      IDEXE_Bubble = 1'b1;
      state_next   = FLUSH;
    end else if (load_use) begin
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      IDEXE_Bubble = 1'b1;
      state_next   = LDSTALL;
    end
  end

  assign Hazard_State = state;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      EXE_ForwardA <= 2'b00;
      EXE_ForwardB <= 2'b00;
`ifdef HAZARD_PERF_EN
      Stall_Cnt    <= 16'd0;
      Flush_Cnt    <= 16'd0;
`endif
    end else begin
      state <= state_next;
      // Forward selects travel with the ID/EXE register: hold on freeze, clear on bubble.
      if (!Freeze) begin
        if (IDEXE_Bubble) begin
          EXE_ForwardA <= 2'b00;
          EXE_ForwardB <= 2'b00;
        end else begin
          EXE_ForwardA <= fwd_a_id;
          EXE_ForwardB <= fwd_b_id;
        end
      end
`ifdef HAZARD_PERF_EN
      if ((state_next == WAIT || state_next == LDSTALL) && Stall_Cnt != 16'hFFFF)
        Stall_Cnt <= Stall_Cnt + 16'd1;
      if (state_next == FLUSH && Flush_Cnt != 16'hFFFF)
        Flush_Cnt <= Flush_Cnt + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: combinational controls checked in-cycle, registered state and
// forward selects checked through an expected queue one edge later.
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       reset;
  logic [4:0] ID_Rs, ID_Rt, EXE_Rw, MEM_Rw;
  logic       ID_UsesRt, EXE_RegWr, EXE_MemtoReg, MEM_RegWr, Branch_Taken, MEM_Busy;
  logic       PC_Write, IFID_Write, IFID_Flush, IDEXE_Bubble, Freeze;
  logic [1:0] EXE_ForwardA, EXE_ForwardB, Hazard_State;
`ifdef HAZARD_PERF_EN
  logic [15:0] Stall_Cnt, Flush_Cnt;
`endif

  hazard_ctrl dut (
    .CLK(CLK), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EXE_Rw(EXE_Rw), .EXE_RegWr(EXE_RegWr), .EXE_MemtoReg(EXE_MemtoReg),
    .MEM_Rw(MEM_Rw), .MEM_RegWr(MEM_RegWr),
    .Branch_Taken(Branch_Taken), .MEM_Busy(MEM_Busy),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEXE_Bubble(IDEXE_Bubble), .Freeze(Freeze),
    .EXE_ForwardA(EXE_ForwardA), .EXE_ForwardB(EXE_ForwardB),
    .Hazard_State(Hazard_State)
`ifdef HAZARD_PERF_EN
    , .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses;
    logic [4:0] ew;
    logic       ewr, eld;
    logic [4:0] mw;
    logic       mwr, br, busy;
  } vec_t;

  // {PC_Write, IFID_Write, IFID_Flush, IDEXE_Bubble, Freeze} and {state, fwdA, fwdB}
  logic [4:0] act_ctrl;
  logic [5:0] act_reg;
  assign act_ctrl = {PC_Write, IFID_Write, IFID_Flush, IDEXE_Bubble, Freeze};
  assign act_reg  = {Hazard_State, EXE_ForwardA, EXE_ForwardB};

  logic [5:0]  exp_q[$];
  logic [4:0]  exp_ctrl;
  logic [5:0]  exp_reg;
  logic [1:0]  m_st, m_fa, m_fb;
  int unsigned m_stall, m_flush;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic vec_t mk(logic [4:0] rs, logic [4:0] rt, logic uses, logic [4:0] ew,
                              logic ewr, logic eld, logic [4:0] mw, logic mwr,
                              logic br, logic busy);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses = uses; v.ew = ew; v.ewr = ewr; v.eld = eld;
    v.mw = mw; v.mwr = mwr; v.br = br; v.busy = busy;
    return v;
  endfunction

  function automatic logic hit(logic [4:0] src, logic [4:0] rw, logic wr);
    return wr && (rw != 5'd0) && (src == rw);
  endfunction

  function automatic vec_t rnd_vec(int maxreg, int br_pct, int busy_pct);
    vec_t v;
    v = mk(5'($urandom_range(0, maxreg)), 5'($urandom_range(0, maxreg)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, maxreg)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, maxreg)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < br_pct), ($urandom_range(0, 99) < busy_pct));
    return v;
  endfunction

  task automatic model_reset();
    m_st = 2'b00; m_fa = 2'b00; m_fb = 2'b00;
    m_stall = 0; m_flush = 0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs (called #1 after a posedge), then predict the outcome.
  task automatic apply(vec_t v);
    logic ea, eb, ma, mb, lu;
    ID_Rs = v.rs; ID_Rt = v.rt; ID_UsesRt = v.uses;
    EXE_Rw = v.ew; EXE_RegWr = v.ewr; EXE_MemtoReg = v.eld;
    MEM_Rw = v.mw; MEM_RegWr = v.mwr; Branch_Taken = v.br; MEM_Busy = v.busy;
    #1;
    ea = hit(v.rs, v.ew, v.ewr);
    eb = v.uses && hit(v.rt, v.ew, v.ewr);
    ma = hit(v.rs, v.mw, v.mwr);
    mb = v.uses && hit(v.rt, v.mw, v.mwr);
    lu = v.eld && (ea || eb);
    if (v.busy) begin
      exp_ctrl = 5'b00001; m_st = 2'b11;
      if (m_stall < 16'hFFFF) m_stall++;
    end else if (v.br) begin
      exp_ctrl = 5'b11110; m_st = 2'b10; m_fa = 2'b00; m_fb = 2'b00;
      if (m_flush < 16'hFFFF) m_flush++;
    end else if (lu) begin
      exp_ctrl = 5'b00010; m_st = 2'b01; m_fa = 2'b00; m_fb = 2'b00;
      if (m_stall < 16'hFFFF) m_stall++;
    end else begin
      exp_ctrl = 5'b11000; m_st = 2'b00;
      m_fa = ea ? 2'b10 : (ma ? 2'b01 : 2'b00);
      m_fb = eb ? 2'b10 : (mb ? 2'b01 : 2'b00);
    end
    exp_q.push_back({m_st, m_fa, m_fb});
  endtask

  task automatic test_reset();
    n_tests++;
    if (act_reg !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_state: state/fwdA/fwdB got %b want 000000", act_reg);
    end
`ifdef HAZARD_PERF_EN
    n_tests++;
    if (Stall_Cnt !== 16'd0 || Flush_Cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", Stall_Cnt, Flush_Cnt);
    end
`endif
  endtask

  task automatic test_independent();
    vec_t v;
    for (int i = 0; i < 8; i++) begin
      v = mk(5'($urandom_range(1, 15)), 5'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
             5'($urandom_range(16, 31)), 1'b1, 1'($urandom_range(0, 1)),
             5'($urandom_range(16, 31)), 1'b1, 1'b0, 1'b0);
      apply(v);
      n_tests++;
      if (act_ctrl !== 5'b11000) begin
        n_fail++;
        $display("FAIL independent_ctrl: got %b want 11000", act_ctrl);
      end
      @(posedge CLK); #1;
      exp_reg = exp_q.pop_front();
      n_tests++;
      if (act_reg !== exp_reg || act_reg !== 6'b000000) begin
        n_fail++;
        $display("FAIL independent_reg: got %b want %b", act_reg, exp_reg);
      end
    end
  endtask

  task automatic test_load_use();
    vec_t seq[3];
    seq[0] = mk(5'd5, 5'd9, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    seq[1] = mk(5'd5, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    seq[2] = mk(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(seq[i]);
      n_tests++;
      if (act_ctrl !== exp_ctrl) begin
        n_fail++;
        $display("FAIL load_use_ctrl[%0d]: got %b want %b", i, act_ctrl, exp_ctrl);
      end
      @(posedge CLK); #1;
      exp_reg = exp_q.pop_front();
      n_tests++;
      if (act_reg !== exp_reg) begin
        n_fail++;
        $display("FAIL load_use_reg[%0d]: got %b want %b", i, act_reg, exp_reg);
      end
      if (i == 1) begin
        n_tests++;
        if (EXE_ForwardA !== 2'b01) begin
          n_fail++;
          $display("FAIL load_use_fwdA: got %b want 01", EXE_ForwardA);
        end
      end
    end
  endtask

  task automatic test_alu_forward();
    vec_t seq[5];
    seq[0] = mk(5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    seq[1] = mk(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    seq[2] = mk(5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    seq[3] = mk(5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    seq[4] = mk(5'd4, 5'd6, 1'b1, 5'd4, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply(seq[i]);
      n_tests++;
      if (act_ctrl !== exp_ctrl) begin
        n_fail++;
        $display("FAIL alu_fwd_ctrl[%0d]: got %b want %b", i, act_ctrl, exp_ctrl);
      end
      @(posedge CLK); #1;
      exp_reg = exp_q.pop_front();
      n_tests++;
      if (act_reg !== exp_reg) begin
        n_fail++;
        $display("FAIL alu_fwd_reg[%0d]: got %b want %b", i, act_reg, exp_reg);
      end
    end
  endtask

  task automatic test_branch();
    apply(mk(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0));
    n_tests++;
    if (act_ctrl !== 5'b11110) begin
      n_fail++;
      $display("FAIL branch_ctrl: got %b want 11110", act_ctrl);
    end
    @(posedge CLK); #1;
    exp_reg = exp_q.pop_front();
    n_tests++;
    if (act_reg !== exp_reg || Hazard_State !== 2'b10) begin
      n_fail++;
      $display("FAIL branch_reg: got %b want %b", act_reg, exp_reg);
    end
  endtask

  task automatic test_freeze();
    vec_t v;
    apply(mk(5'd8, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0));
    @(posedge CLK); #1;
    exp_reg = exp_q.pop_front();
    n_tests++;
    if (act_reg !== exp_reg) begin
      n_fail++;
      $display("FAIL freeze_setup: got %b want %b", act_reg, exp_reg);
    end
    for (int i = 0; i < 3; i++) begin
      v = rnd_vec(3, 50, 0);
      v.busy = 1'b1;
      apply(v);
      n_tests++;
      if (act_ctrl !== 5'b00001) begin
        n_fail++;
        $display("FAIL freeze_ctrl[%0d]: got %b want 00001", i, act_ctrl);
      end
      @(posedge CLK); #1;
      exp_reg = exp_q.pop_front();
      n_tests++;
      if (act_reg !== exp_reg || act_reg !== 6'b111010) begin
        n_fail++;
        $display("FAIL freeze_reg[%0d]: got %b want %b", i, act_reg, exp_reg);
      end
    end
    apply(mk(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0));
    n_tests++;
    if (act_ctrl !== 5'b11110) begin
      n_fail++;
      $display("FAIL freeze_then_branch: got %b want 11110", act_ctrl);
    end
    @(posedge CLK); #1;
    exp_reg = exp_q.pop_front();
    n_tests++;
    if (act_reg !== exp_reg) begin
      n_fail++;
      $display("FAIL freeze_then_branch_reg: got %b want %b", act_reg, exp_reg);
    end
  endtask

  task automatic test_reset_mid();
    apply(mk(5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0));
    @(posedge CLK); #1;
    exp_reg = exp_q.pop_front();
    n_tests++;
    if (act_reg !== exp_reg || Hazard_State !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_mid_ldstall: got %b want %b", act_reg, exp_reg);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (act_reg !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b want 000000", act_reg);
    end
    @(posedge CLK); #1;
    reset = 1'b1;
    model_reset();
    // Second case: reset during a freeze with forward selects holding 10.
    apply(mk(5'd8, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0));
    @(posedge CLK); #1;
    void'(exp_q.pop_front());
    apply(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1));
    @(posedge CLK); #1;
    exp_reg = exp_q.pop_front();
    n_tests++;
    if (act_reg !== exp_reg || act_reg !== 6'b111010) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got %b want %b", act_reg, exp_reg);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (act_reg !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_mid_wait_async: got %b want 000000", act_reg);
    end
`ifdef HAZARD_PERF_EN
    n_tests++;
    if (Stall_Cnt !== 16'd0 || Flush_Cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_counters: got %0d/%0d want 0/0", Stall_Cnt, Flush_Cnt);
    end
`endif
    MEM_Busy = 1'b0;
    @(posedge CLK); #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      apply(rnd_vec(3, 15, 15));
      n_tests++;
      if (act_ctrl !== exp_ctrl) begin
        n_fail++;
        $display("FAIL random_ctrl[%0d]: got %b want %b", i, act_ctrl, exp_ctrl);
      end
      @(posedge CLK); #1;
      exp_reg = exp_q.pop_front();
      n_tests++;
      if (act_reg !== exp_reg) begin
        n_fail++;
        $display("FAIL random_reg[%0d]: got %b want %b", i, act_reg, exp_reg);
      end
    end
`ifdef HAZARD_PERF_EN
    n_tests++;
    if (Stall_Cnt !== 16'(m_stall) || Flush_Cnt !== 16'(m_flush)) begin
      n_fail++;
      $display("FAIL perf_counters: got %0d/%0d want %0d/%0d",
               Stall_Cnt, Flush_Cnt, m_stall, m_flush);
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0;
    EXE_Rw = '0; EXE_RegWr = 1'b0; EXE_MemtoReg = 1'b0;
    MEM_Rw = '0; MEM_RegWr = 1'b0; Branch_Taken = 1'b0; MEM_Busy = 1'b0;
    model_reset();
    #12;
    test_reset();
    @(posedge CLK); #1;
    reset = 1'b1;
    test_independent();
    test_load_use();
    test_alu_forward();
    test_branch();
    test_freeze();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage pipeline. It watches the destination fields that leave the ID/EXE and EXE/MEM pipeline registers and drives control back upstream: hold and bubble signals into PC, IF/ID and ID/EXE, and forwarding selects. Forwarding selects are decided in ID and registered so they arrive in EXE alongside the operands. It resolves load-use stalls, taken-branch flushes and multi-cycle data-memory waits with a small state machine.

## Interface
Parameters:
- none

Ports (async active-low reset, single clock):
- CLK  in  1  pipeline clock, all state on posedge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- ID_Rs  in  5  source register A of the instruction in ID
- ID_Rt  in  5  source register B of the instruction in ID
- ID_UsesRt  in  1  1 = ID instruction reads Rt as an operand
- EXE_Rw  in  5  destination of the instruction in EXE
- EXE_RegWr  in  1  EXE instruction writes the register file
- EXE_MemtoReg  in  1  EXE instruction is a load
- MEM_Rw  in  5  destination of the instruction in MEM
- MEM_RegWr  in  1  MEM instruction writes the register file
- Branch_Taken  in  1  branch in EXE resolved taken this cycle
- MEM_Busy  in  1  data memory not ready; pipeline must freeze
- PC_Write  out  1  1 = PC may update
- IFID_Write  out  1  1 = IF/ID may load
- IFID_Flush  out  1  1 = IF/ID loads a NOP
- IDEXE_Bubble  out  1  1 = ID/EXE loads all-zero control
- Freeze  out  1  1 = every pipeline register holds
- EXE_ForwardA  out  2  operand A select in EXE: 00 regfile, 10 from MEM, 01 from WB
- EXE_ForwardB  out  2  operand B select, same encoding
- Hazard_State  out  2  current FSM state, debug

## Operation
- Match rule: a source matches a stage when source == Rw, Rw != 0 and that stage's RegWr = 1. Rt is compared only when ID_UsesRt = 1.
- Load-use: EXE_MemtoReg = 1 and a match on EXE.
- Per-cycle priority, evaluated combinationally:
  - MEM_Busy: Freeze = 1, PC_Write = IFID_Write = 0, no flush, no bubble.
  - Branch_Taken: IFID_Flush = 1, IDEXE_Bubble = 1, PC_Write = IFID_Write = 1.
  - Load-use: PC_Write = IFID_Write = 0, IDEXE_Bubble = 1.
  - Otherwise: PC_Write = IFID_Write = 1, all others 0.
- Forward decision for each operand, computed in ID:
  - Match on EXE gives 10.
  - Else a match on MEM gives 01.
  - Else 00.
  - EXE takes precedence over MEM when both match.
- EXE_ForwardA/B registers, loaded on posedge:
  - Freeze: hold.
  - IDEXE_Bubble: load 00.
  - Otherwise: load the ID decision.
- FSM states: RUN = 00, LDSTALL = 01, FLUSH = 10, WAIT = 11. The next state is the cause chosen this cycle: WAIT, FLUSH, LDSTALL or RUN. Hazard_State shows the registered state.
- After a load-use stall the bubble is in EXE and the load is in MEM. No new stall is raised; the ID instruction forwards 01.

## Timing
- Reset values, asynchronous: EXE_ForwardA/B = 00, Hazard_State = RUN, counters = 0.
- Control outputs are combinational from current inputs; they are valid in the same cycle.
- Forward selects have 1-cycle latency, aligned with the ID/EXE register.
- A load-use stall costs exactly 1 cycle.
- A taken branch costs 2 squashed instructions, both removed in the same cycle.
- MEM_Busy held for N cycles freezes the pipeline for exactly N cycles. Forward registers hold through the freeze.
- Branch_Taken together with MEM_Busy: the freeze wins. The branch must still be asserted when MEM_Busy drops.
- Reset asserted mid-stall: all state clears and the outputs show the RUN values, since the reset inputs to the other stages bubble the pipe.

## Configuration
- HAZARD_PERF_EN defined:
  - Adds outputs Stall_Cnt[15:0] and Flush_Cnt[15:0], both reset to 0.
  - Stall_Cnt increments on each load-use or freeze cycle.
  - Flush_Cnt increments on each taken-branch cycle.
  - Both saturate at 16'hFFFF.
- HAZARD_PERF_EN undefined: no counters and no extra ports. All other behaviour is identical.

## Test plan
- Independent instruction stream, no matches: PC_Write = 1 every cycle, forwards 00, Hazard_State = RUN.
- EXE load with EXE_Rw = 5, ID_Rs = 5: that cycle PC_Write = 0 and IDEXE_Bubble = 1. Next cycle (MEM_Rw = 5) there is no stall and EXE_ForwardA = 01 one cycle later.
- ALU op in EXE with Rw = 7, ID_Rt = 7, ID_UsesRt = 1: no stall, EXE_ForwardB = 10 on the next edge. With EXE_Rw = 0 instead, the forward stays 00.
- Branch_Taken while a load-use condition is also present: IFID_Flush = IDEXE_Bubble = 1, PC_Write = 1, next state FLUSH.
- MEM_Busy for 3 cycles with the forward registers at 10: Freeze = 1 for 3 cycles, forwards stay 10, Hazard_State = WAIT. With HAZARD_PERF_EN, Stall_Cnt = 3.
- Drop reset to 0 during LDSTALL: Hazard_State = 00 and forwards = 00 immediately, without waiting for a clock edge.
